stopwatch_count_reg: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/stopwatch_count_reg_if.sv | 28 ++
 rtl/stopwatch_count_reg.sv | 81 ++++++++
 tb/tb_stopwatch_count_reg.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch types and constants
package stopwatch_pkg;

  localparam int CNT_W     = 16;
  localparam int MAX_COUNT = 59999;
  localparam int STEP      = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

endpackage

// File: rtl/stopwatch_count_reg_if.sv
// rtl/stopwatch_count_reg_if.sv - operand/result bus between count register and ripple adder
interface stopwatch_count_reg_if
  import stopwatch_pkg::*;
();

  logic [CNT_W-1:0] op_a;
  logic [CNT_W-1:0] op_b;
  logic             cin_out;
  logic [CNT_W-1:0] sum_in;
  logic             carry_in;

  modport master (
    output op_a,
    output op_b,
    output cin_out,
    input  sum_in,
    input  carry_in
  );

  modport slave (
    input  op_a,
    input  op_b,
    input  cin_out,
    output sum_in,
    output carry_in
  );

endinterface

// File: rtl/stopwatch_count_reg.sv
// rtl/stopwatch_count_reg.sv - stopwatch count register, lap capture and run/pause FSM
module stopwatch_count_reg
  import stopwatch_pkg::*;
#(
  parameter int STEP      = stopwatch_pkg::STEP,
  parameter int MAX_COUNT = stopwatch_pkg::MAX_COUNT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick_en,
  input  logic                         start_stop,
  input  logic                         lap,
  input  logic                         clear,
  stopwatch_count_reg_if.master        adder,
  output logic [CNT_W-1:0]             count_q,
  output logic [CNT_W-1:0]             lap_q,
  output logic                         lap_valid,
  output logic                         running,
  output logic                         overflow
);

  localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(STEP);
  localparam logic [CNT_W-1:0] WRAP_AT = CNT_W'(MAX_COUNT - STEP);

  sw_state_t state;
  sw_state_t state_nxt;

  assign adder.op_a    = count_q;
  assign adder.op_b    = STEP_V;
  assign adder.cin_out = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    running = (state == RUN);
  end

  // Tick and lap both act on the state and count held at the start of the cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q   <= '0;
      lap_q     <= '0;
      lap_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (state == RUN && tick_en) begin
        if (adder.carry_in || count_q > WRAP_AT) begin
          count_q  <= '0;
          overflow <= 1'b1;
        end else begin
          count_q <= adder.sum_in;
        end
      end
      if (lap && state != IDLE) begin
        lap_q     <= count_q;
        lap_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_count_reg.sv
// tb/tb_stopwatch_count_reg.sv - self-checking bench for stopwatch_count_reg
module tb_stopwatch_count_reg;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst, tick_en, start_stop, lap, clear;
  logic [CNT_W-1:0] count_q, lap_q;
  logic lap_valid, running, overflow;

  int n_checks = 0;
  int n_errors = 0;

  stopwatch_count_reg_if bus ();

  // Behavioural stand-in for the external 16-bit ripple adder.
  assign {bus.carry_in, bus.sum_in} = {1'b0, bus.op_a} + {1'b0, bus.op_b} + {16'd0, bus.cin_out};

  stopwatch_count_reg dut (
    .clk        (clk),
    .rst        (rst),
    .tick_en    (tick_en),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .adder      (bus.master),
    .count_q    (count_q),
    .lap_q      (lap_q),
    .lap_valid  (lap_valid),
    .running    (running),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;
  int m_state, m_count, m_lap;
  bit m_lv, m_ovf;

  typedef struct {
    bit rst, clr, ss, lp, tk;
    int count, lapv;
    bit lv, run, ovf;
  } vec_t;
  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(bit r, bit c, bit ss, bit lp, bit tk);
    int old_state, old_count;
    if (r || c) begin
      m_state = S_IDLE; m_count = 0; m_lap = 0; m_lv = 0; m_ovf = 0;
      return;
    end
    old_state = m_state;
    old_count = m_count;
    if (old_state == S_RUN && tk) begin
      if (old_count + STEP > MAX_COUNT) begin
        m_count = 0;
        m_ovf   = 1;
      end else begin
        m_count = old_count + STEP;
      end
    end
    if (lp && old_state != S_IDLE) begin
      m_lap = old_count;
      m_lv  = 1;
    end
    if (ss) m_state = (old_state == S_RUN) ? S_PAUSE : S_RUN;
  endfunction

  // One clock with the given pulses; checks every output against the model.
  task automatic cyc(input bit r, input bit c, input bit ss, input bit lp, input bit tk);
    rst = r; clear = c; start_stop = ss; lap = lp; tick_en = tk;
    model_step(r, c, ss, lp, tk);
    @(posedge clk);
    #1;
    rst = 0; clear = 0; start_stop = 0; lap = 0; tick_en = 0;
    chk("count_q", count_q, m_count);
    chk("lap_q", lap_q, m_lap);
    chk("lap_valid", lap_valid, m_lv);
    chk("running", running, m_state == S_RUN);
    chk("overflow", overflow, m_ovf);
    chk("op_a", bus.op_a, m_count);
    chk("op_b", bus.op_b, STEP);
    chk("cin_out", bus.cin_out, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 1);
  endtask

  function automatic vec_t mk(bit r, bit c, bit ss, bit lp, bit tk, int cnt, int lv_q, bit lv, bit run, bit ovf);
    vec_t v;
    v.rst = r; v.clr = c; v.ss = ss; v.lp = lp; v.tk = tk;
    v.count = cnt; v.lapv = lv_q; v.lv = lv; v.run = run; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    rst = 1; clear = 0; start_stop = 0; lap = 0; tick_en = 0;
    m_state = S_IDLE; m_count = 0; m_lap = 0; m_lv = 0; m_ovf = 0;

    //           rst clr ss lp tk  count lap lv run ovf
    tbl[0]  = mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0,  0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1,  1, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 1,  2, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0, 1,  3, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 1,  4, 0, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 1,  5, 0, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0,  5, 5, 1, 1, 0);
    tbl[8]  = mk(0, 0, 1, 0, 1,  6, 5, 1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1,  6, 5, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 1, 0,  6, 6, 1, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 1,  0, 0, 0, 0, 0);
    tbl[13] = mk(0, 0, 1, 0, 1,  0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 1,  1, 0, 0, 1, 0);
    tbl[15] = mk(0, 1, 1, 1, 1,  0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rst, tbl[i].clr, tbl[i].ss, tbl[i].lp, tbl[i].tk);
      chk($sformatf("tbl%0d.count", i), count_q, tbl[i].count);
      chk($sformatf("tbl%0d.lap", i), lap_q, tbl[i].lapv);
      chk($sformatf("tbl%0d.lap_valid", i), lap_valid, tbl[i].lv);
      chk($sformatf("tbl%0d.running", i), running, tbl[i].run);
      chk($sformatf("tbl%0d.overflow", i), overflow, tbl[i].ovf);
    end

    // Wrap at the top of the range.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(59998);
    chk("pre_wrap", count_q, 59998);
    cyc(0, 0, 0, 0, 1);
    chk("at_max", count_q, 59999);
    chk("at_max_ovf", overflow, 0);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_count", count_q, 0);
    chk("wrap_ovf", overflow, 1);
    cyc(0, 0, 0, 0, 1);
    chk("ovf_sticky", overflow, 1);
    cyc(0, 1, 0, 0, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_running", running, 0);

    // Stop with coincident tick, then pause ignores ticks.
    cyc(0, 0, 1, 0, 0);
    ticks(100);
    cyc(0, 0, 1, 0, 1);
    chk("stop_tick_count", count_q, 101);
    chk("stop_tick_running", running, 0);
    cyc(0, 0, 0, 0, 1);
    chk("pause_tick", count_q, 101);

    // Lap in pause, then lap coincident with a tick captures pre-increment.
    cyc(0, 0, 1, 0, 1);
    chk("resume_tick_ignored", count_q, 101);
    ticks(149);
    cyc(0, 0, 1, 0, 0);
    chk("paused_250", count_q, 250);
    cyc(0, 0, 0, 1, 0);
    chk("lap_pause", lap_q, 250);
    chk("lap_pause_valid", lap_valid, 1);
    cyc(0, 0, 1, 0, 0);
    ticks(2);
    cyc(0, 0, 0, 1, 1);
    chk("lap_tick_lap", lap_q, 252);
    chk("lap_tick_count", count_q, 253);

    // Clear wins over start_stop.
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    ticks(40);
    cyc(0, 1, 1, 0, 0);
    chk("clr_ss_count", count_q, 0);
    chk("clr_ss_running", running, 0);

    // Reset mid-run discards a coincident tick.
    cyc(0, 0, 1, 0, 0);
    ticks(777);
    cyc(0, 0, 0, 1, 0);
    chk("pre_rst_lv", lap_valid, 1);
    cyc(1, 0, 1, 1, 1);
    chk("rst_count", count_q, 0);
    chk("rst_lap", lap_q, 0);
    chk("rst_lv", lap_valid, 0);
    chk("rst_running", running, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
